// File: rtl/pulse_meter.sv
// pulse_meter: measures each stable level of a filtered signal in cycles and reports it on a valid/ready port.
// Define PULSE_METER_PERIOD_EN to add o_period_out (last reported high width + low width).
module pulse_meter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sig_in,
    input  logic             i_rd_ready,
    output logic             o_res_valid,
    output logic [CNT_W-1:0] o_width_out,
    output logic             o_level_out,
    output logic             o_width_sat,
    output logic             o_overrun
`ifdef PULSE_METER_PERIOD_EN
    ,
    output logic [CNT_W:0]   o_period_out
`endif
);
    typedef enum logic [1:0] {ARM, WAIT_EDGE, MEASURE} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t             r_state, w_next;
    logic               r_sig_d, r_sat, r_valid, r_level, r_wsat, r_overrun;
    logic [CNT_W-1:0]   r_cnt, r_width, w_cnt_inc;
    logic               w_edge, w_load, w_drop, w_accept;
    always_ff @(posedge i_clk) begin
        r_state <= !i_rst_n ? ARM : w_next;
    end
    always_comb begin
        w_edge    = i_sig_in != r_sig_d;
        w_next    = (r_state == ARM) ? WAIT_EDGE : (r_state == WAIT_EDGE && !w_edge) ? WAIT_EDGE : MEASURE;
        w_load    = r_state == MEASURE && w_edge && (!r_valid || i_rd_ready);
        w_drop    = r_state == MEASURE && w_edge && r_valid && !i_rd_ready;
        w_accept  = r_valid && i_rd_ready;
        w_cnt_inc = (r_cnt == MAX) ? MAX : r_cnt + 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sig_d   <= 1'b0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            r_width   <= '0;
            r_level   <= 1'b0;
            r_wsat    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sig_d <= i_sig_in;
            // the edge ending the first partial level only starts counting
            if (r_state != ARM && w_edge) begin
                r_cnt <= CNT_W'(1);
                r_sat <= 1'b0;
            end else if (r_state == MEASURE) begin
                r_cnt <= w_cnt_inc;
                r_sat <= r_sat | (w_cnt_inc == MAX);
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_width <= r_cnt;
                r_level <= r_sig_d;
                r_wsat  <= r_sat;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_drop) r_overrun <= 1'b1;
        end
    end
`ifdef PULSE_METER_PERIOD_EN
    logic [CNT_W-1:0] r_last_hi, r_last_lo;
    logic             r_hi_seen;
    logic [CNT_W:0]   r_period;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_hi <= '0;
            r_last_lo <= '0;
            r_hi_seen <= 1'b0;
            r_period  <= '0;
        end else if (w_load && r_sig_d) begin
            r_last_hi <= r_cnt;
            r_hi_seen <= 1'b1;
            r_period  <= '0;
        end else if (w_load) begin
            r_last_lo <= r_cnt;
            r_period  <= r_hi_seen ? {1'b0, r_last_hi} + {1'b0, r_cnt} : '0;
        end else if (w_accept) begin
            r_period <= '0;
        end
    end
    assign o_period_out = r_period;
`endif
    assign o_res_valid = r_valid;
    assign o_width_out = r_width;
    assign o_level_out = r_level;
    assign o_width_sat = r_wsat;
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: random and directed level sequences against a duration/handshake model, scoreboard-checked.
module tb_pulse_meter;
    localparam int W    = 4;
    localparam int MAXW = (1 << W) - 1;
    logic         clk = 0, rst_n = 0, sig = 0, rdy = 0;
    logic         vld, lvl, wsat, ovr_o;
    logic [W-1:0] wid;
`ifdef PULSE_METER_PERIOD_EN
    logic [W:0]   per;
`endif
    always #5 clk = ~clk;
    pulse_meter #(.CNT_W(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sig_in(sig), .i_rd_ready(rdy),
        .o_res_valid(vld), .o_width_out(wid), .o_level_out(lvl),
        .o_width_sat(wsat), .o_overrun(ovr_o)
`ifdef PULSE_METER_PERIOD_EN
        , .o_period_out(per)
`endif
    );
    typedef struct {int width; int level; int sat; int vis; int period;} res_t;
    res_t q[$];
    int   vectors = 0, errs = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // model state: levels are measured between consecutive edges in sample-cycle numbers
    bit   arm, have_edge, pend, m_ovr, hi_seen;
    logic prev;
    int   last_e, last_hi;
    task automatic step(input logic s, input logic r);
        int   d;
        res_t e;
        sig = s;
        rdy = r;
        if (arm) arm = 0;
        else if (s != prev) begin
            if (have_edge) begin
                if (!pend || r) begin
                    d = cyc - last_e;
                    e.width = d > MAXW ? MAXW : d;
                    e.level = int'(prev);
                    e.sat = int'(d >= MAXW);
                    e.vis = cyc + 1;
                    e.period = (e.level == 0 && hi_seen) ? last_hi + e.width : 0;
                    if (e.level == 1) begin
                        last_hi = e.width;
                        hi_seen = 1;
                    end
                    q.push_back(e);
                    pend = 1;
                end else m_ovr = 1;
            end
            have_edge = 1;
            last_e = cyc;
        end else if (pend && r) pend = 0;
        prev = s;
        @(posedge clk);
        #1;
        chk("overrun", int'(ovr_o), int'(m_ovr));
    endtask
    task automatic hold(input logic s, input int n, input logic r);
        repeat (n) step(s, r);
    endtask
    task automatic rlevel(input logic s, input int n);
        repeat (n) step(s, $urandom_range(0, 3) != 0);
    endtask
    task automatic do_reset(input int n);
        rst_n = 0;
        q.delete();
        arm = 1; have_edge = 0; pend = 0; m_ovr = 0; hi_seen = 0; prev = 0;
        repeat (n) begin
            sig = ~sig;
            rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("reset_outputs", int'({vld, wid, lvl, wsat, ovr_o}), 0);
`ifdef PULSE_METER_PERIOD_EN
            chk("reset_period", int'(per), 0);
`endif
        end
        rst_n = 1;
    endtask
    res_t cur;
    bit   have_cur = 0, prev_v = 0, prev_a = 0;
    task automatic cmp_fields();
        chk("width", int'(wid), cur.width);
        chk("level", int'(lvl), cur.level);
        chk("width_sat", int'(wsat), cur.sat);
`ifdef PULSE_METER_PERIOD_EN
        chk("period", int'(per), cur.period);
`endif
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
            prev_a = 0;
            have_cur = 0;
        end else begin
            if (vld) begin
                if (!prev_v || prev_a) begin
                    if (q.size() == 0) begin
                        vectors++;
                        errs++;
                        have_cur = 0;
                        $display("FAIL unexpected_result: got width %0d level %0d, expected no result", wid, lvl);
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1;
                        chk("latency", cyc, cur.vis);
                        cmp_fields();
                    end
                end else if (have_cur) cmp_fields();
            end
            prev_v = vld;
            prev_a = vld && rdy;
        end
    end
    initial begin
        logic s;
        do_reset(5);
        repeat (4) begin
            hold(1, 5, 1);
            hold(0, 3, 1);
        end
        hold(1, 4, 1);
        hold(0, 6, 0);
        hold(1, 2, 0);
        hold(0, 3, 0);
        step(0, 1);
        chk("valid_after_accept", int'(vld), 0);
        chk("overrun_sticky", int'(ovr_o), 1);
        hold(0, 2, 0);
        do_reset(2);
        hold(1, 3, 0);
        hold(0, 4, 0);
        hold(1, 5, 0);
        step(0, 1);
        chk("valid_on_accept_and_edge", int'(vld), 1);
        hold(0, 3, 0);
        hold(1, 20, 1);
        hold(0, 3, 1);
        hold(1, 2, 1);
        s = 1;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) do_reset(3);
            s = ~s;
            rlevel(s, $urandom_range(1, 20));
        end
        hold(s, 6, 1);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
